// File: rtl/wb_arb_pkg.sv
// Shared types and the arbitration helper for the Wishbone round-robin arbiter.
// rr_pick works on a fixed 8-bit request vector so one function serves every NUM_MASTERS.
package wb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = 3;

  // One-hot winner: first set bit of req searching last+1, last+2, ... modulo n.
  // Passing last = n-1 gives plain lowest-index-wins priority.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input int unsigned            last,
    input int unsigned            n
  );
    logic [MAX_MASTERS-1:0] gnt;
    int unsigned            idx;
    gnt = '0;
    for (int unsigned k = 1; k <= MAX_MASTERS; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && gnt == '0 && req[idx[MAX_IDX_W-1:0]]) begin
        gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Ack watchdog for the current owner's strobe: pulses o_timeout on the
// TIMEOUT_CYCLES-th consecutive un-acked strobe cycle, then starts over.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_ack,
  output logic o_timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  assign o_timeout = i_active & ~i_ack & (r_count == LIMIT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (!i_active || i_ack || o_timeout) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone classic N:1 arbiter with registered one-hot grant, bus locking
// for the owner's whole cyc tenure and an optional per-transfer ack timeout.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic                                 s_we_o,
  output logic [ADDR_WIDTH-1:0]                s_adr_o,
  output logic [DATA_WIDTH-1:0]                s_dat_o,
  output logic [DATA_WIDTH/8-1:0]              s_sel_o,
  input  logic                                 s_ack_i,
  input  logic [DATA_WIDTH-1:0]                s_dat_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 busy_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic [NUM_MASTERS-1:0]    r_grant;
  logic [NUM_MASTERS-1:0]    w_grant_nxt;
  // Owner index while OWNED; remembers the most recent winner while IDLE.
  logic [IDX_W-1:0]          r_last;
  logic [IDX_W-1:0]          w_last_nxt;

  logic                      w_owned;
  logic                      w_own_cyc;
  logic                      w_own_stb;
  logic                      w_timeout;
  logic [MAX_MASTERS-1:0]    w_req_ext;
  logic [MAX_MASTERS-1:0]    w_pick_ext;
  logic [IDX_W-1:0]          w_pick_idx;
  int unsigned               w_search_from;

  assign w_owned   = (r_state == OWNED);
  assign w_own_cyc = w_owned & m_cyc_i[r_last];
  assign w_own_stb = w_own_cyc & m_stb_i[r_last];

  assign m_dat_o = s_dat_i;
  assign grant_o = r_grant;
  assign busy_o  = w_owned;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path
  // through the block leaves one unassigned and infers a latch.
  always_comb begin
    w_req_ext                  = '0;
    w_req_ext[NUM_MASTERS-1:0] = m_cyc_i;
    if (FIXED_PRIORITY != 0) w_search_from = NUM_MASTERS - 1;
    else                     w_search_from = 32'(r_last);
    w_pick_ext = rr_pick(w_req_ext, w_search_from, NUM_MASTERS);
    w_pick_idx = '0;
    for (int k = 0; k < MAX_MASTERS; k++) begin
      if (w_pick_ext[k]) w_pick_idx = IDX_W'(k);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    m_ack_o     = '0;
    m_err_o     = '0;

    case (r_state)
      IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = OWNED;
          w_grant_nxt = w_pick_ext[NUM_MASTERS-1:0];
          w_last_nxt  = w_pick_idx;
        end
      end
      OWNED: begin
        // A timeout cycle withdraws the strobe so the slave sees the transfer end.
        s_cyc_o = w_own_cyc & ~w_timeout;
        s_stb_o = w_own_stb & ~w_timeout;
        s_we_o  = m_we_i[r_last];
        s_adr_o = m_adr_i[r_last*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat_o = m_dat_i[r_last*DATA_WIDTH +: DATA_WIDTH];
        s_sel_o = m_sel_i[r_last*SEL_W +: SEL_W];
        m_ack_o = r_grant & {NUM_MASTERS{s_ack_i & m_stb_i[r_last]}};
        m_err_o = r_grant & {NUM_MASTERS{w_timeout}};
        if (!w_own_cyc) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_active  (w_own_stb),
        .i_ack     (s_ack_i),
        .o_timeout (w_timeout)
      );
    end else begin : g_no_timeout
      assign w_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench: directed vector table and corner sequences on 2-master
// instances, plus randomized traffic on a 4-master instance against a reference model.
module tb_wb_rr_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int C_N = 4;
  localparam int C_T = 5;
  localparam logic [AW-1:0] A_ADR0 = 32'h1000_0004;
  localparam logic [AW-1:0] A_ADR1 = 32'h8000_0010;
  localparam logic [SW-1:0] A_SEL0 = 4'b1100;
  localparam logic [SW-1:0] A_SEL1 = 4'b0011;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Instance A: 2 masters, round-robin, timeout 4
  logic [1:0]      a_cyc, a_stb, a_we, a_mack, a_merr, a_grant;
  logic [2*AW-1:0] a_adr;
  logic [2*DW-1:0] a_dat;
  logic [2*SW-1:0] a_sel;
  logic            a_sack, a_scyc, a_sstb, a_swe, a_busy;
  logic [DW-1:0]   a_sdat, a_mdat, a_sdo;
  logic [AW-1:0]   a_sadr;
  logic [SW-1:0]   a_ssel;

  // Instance B: 2 masters, fixed priority, no timeout
  logic [1:0]      b_cyc, b_stb, b_we, b_mack, b_merr, b_grant;
  logic [2*AW-1:0] b_adr;
  logic [2*DW-1:0] b_dat;
  logic [2*SW-1:0] b_sel;
  logic            b_sack, b_scyc, b_sstb, b_swe, b_busy;
  logic [DW-1:0]   b_sdat, b_mdat, b_sdo;
  logic [AW-1:0]   b_sadr;
  logic [SW-1:0]   b_ssel;

  // Instance C: 4 masters, round-robin, timeout 5
  logic [C_N-1:0]    c_cyc, c_stb, c_we, c_mack, c_merr, c_grant;
  logic [C_N*AW-1:0] c_adr;
  logic [C_N*DW-1:0] c_dat;
  logic [C_N*SW-1:0] c_sel;
  logic              c_sack, c_scyc, c_sstb, c_swe, c_busy;
  logic [DW-1:0]     c_sdat, c_mdat, c_sdo;
  logic [AW-1:0]     c_sadr;
  logic [SW-1:0]     c_ssel;

  wb_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .reset(reset),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we), .m_adr_i(a_adr),
    .m_dat_i(a_dat), .m_sel_i(a_sel), .m_ack_o(a_mack), .m_err_o(a_merr),
    .m_dat_o(a_mdat), .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
    .s_adr_o(a_sadr), .s_dat_o(a_sdo), .s_sel_o(a_ssel), .s_ack_i(a_sack),
    .s_dat_i(a_sdat), .grant_o(a_grant), .busy_o(a_busy)
  );

  wb_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .FIXED_PRIORITY(1), .TIMEOUT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we), .m_adr_i(b_adr),
    .m_dat_i(b_dat), .m_sel_i(b_sel), .m_ack_o(b_mack), .m_err_o(b_merr),
    .m_dat_o(b_mdat), .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
    .s_adr_o(b_sadr), .s_dat_o(b_sdo), .s_sel_o(b_ssel), .s_ack_i(b_sack),
    .s_dat_i(b_sdat), .grant_o(b_grant), .busy_o(b_busy)
  );

  wb_rr_arbiter #(.NUM_MASTERS(C_N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .FIXED_PRIORITY(0), .TIMEOUT_CYCLES(C_T)) u_c (
    .clk(clk), .reset(reset),
    .m_cyc_i(c_cyc), .m_stb_i(c_stb), .m_we_i(c_we), .m_adr_i(c_adr),
    .m_dat_i(c_dat), .m_sel_i(c_sel), .m_ack_o(c_mack), .m_err_o(c_merr),
    .m_dat_o(c_mdat), .s_cyc_o(c_scyc), .s_stb_o(c_sstb), .s_we_o(c_swe),
    .s_adr_o(c_sadr), .s_dat_o(c_sdo), .s_sel_o(c_ssel), .s_ack_i(c_sack),
    .s_dat_i(c_sdat), .grant_o(c_grant), .busy_o(c_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic [1:0] grant;
    logic [1:0] mack;
    logic       scyc;
    logic       sstb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    a_cyc  = '0; a_stb = '0; a_sack = 1'b0; a_sdat = '0;
    b_cyc  = '0; b_stb = '0; b_sack = 1'b0; b_sdat = '0;
    c_cyc  = '0; c_stb = '0; c_sack = 1'b0; c_sdat = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Reference model state for instance C (owner -1 means idle)
  int         m_owner, m_last, m_cnt, o, n_ack0, n_to;
  bit         owned, ocyc, ostb, to, prev_ack0;
  logic [3:0] e_grant, e_mack, e_merr, c_drop, prev_g;
  logic [AW-1:0] e_sadr;
  logic [SW-1:0] e_ssel;
  int         order [$];

  initial begin
    vecs[0]  = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2'b11, 1'b1, 2'b01, 2'b01, 1'b1, 1'b1};
    vecs[2]  = '{2'b10, 2'b10, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 2'b11, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    vecs[5]  = '{2'b11, 2'b01, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    vecs[6]  = '{2'b01, 2'b01, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 2'b01, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    vecs[10] = '{2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    a_we  = 2'b10; a_adr = {A_ADR1, A_ADR0}; a_sel = {A_SEL1, A_SEL0};
    a_dat = {32'h5555_1111, 32'hAAAA_0000};
    b_we  = '0; b_adr = '0; b_dat = '0; b_sel = '0;
    c_we  = '0; c_adr = '0; c_dat = '0; c_sel = '0;

    do_reset();
    @(negedge clk);
    check("rst_grant", a_grant, 2'b00);
    check("rst_busy", a_busy, 1'b0);
    check("rst_scyc", a_scyc, 1'b0);
    tick();

    // Directed vector table on instance A
    for (int i = 0; i < 12; i++) begin
      a_cyc  = vecs[i].cyc;
      a_stb  = vecs[i].stb;
      a_sack = vecs[i].ack;
      a_sdat = $urandom;
      @(negedge clk);
      check("vec_grant", a_grant, vecs[i].grant);
      check("vec_mack", a_mack, vecs[i].mack);
      check("vec_merr", a_merr, 2'b00);
      check("vec_scyc", a_scyc, vecs[i].scyc);
      check("vec_sstb", a_sstb, vecs[i].sstb);
      check("vec_busy", a_busy, vecs[i].grant != 2'b00);
      check("vec_sadr", a_sadr, (vecs[i].grant == 2'b01) ? A_ADR0 :
                                (vecs[i].grant == 2'b10) ? A_ADR1 : 32'h0);
      check("vec_ssel", a_ssel, (vecs[i].grant == 2'b01) ? A_SEL0 :
                                (vecs[i].grant == 2'b10) ? A_SEL1 : 4'h0);
      check("vec_swe", a_swe, vecs[i].grant == 2'b10);
      check("vec_mdat", a_mdat, a_sdat);
      tick();
    end

    // Timeout: no ack -> err on 4th and 8th stb cycles; ack on the 4th wins
    a_cyc = 2'b01; a_stb = 2'b01; a_sack = 1'b0;
    @(negedge clk);
    check("to_idle", a_grant, 2'b00);
    tick();
    for (int i = 1; i <= 12; i++) begin
      a_sack = (i == 12);
      @(negedge clk);
      check("to_grant", a_grant, 2'b01);
      check("to_err", a_merr, (i == 4 || i == 8) ? 2'b01 : 2'b00);
      check("to_stb", a_sstb, (i == 4 || i == 8) ? 1'b0 : 1'b1);
      check("to_ack", a_mack, (i == 12) ? 2'b01 : 2'b00);
      tick();
    end

    // Asynchronous reset mid-transfer while master 0 owns the bus
    a_sack = 1'b0;
    @(negedge clk);
    check("rst_pre_stb", a_sstb, 1'b1);
    #2;
    reset  = 1'b1;
    a_sack = 1'b1;
    #1;
    check("rst_async_stb", a_sstb, 1'b0);
    check("rst_async_cyc", a_scyc, 1'b0);
    check("rst_async_grant", a_grant, 2'b00);
    check("rst_async_busy", a_busy, 1'b0);
    check("rst_async_ack", a_mack, 2'b00);
    check("rst_async_err", a_merr, 2'b00);
    check("rst_async_adr", a_sadr, 32'h0);
    tick();
    reset = 1'b0; a_cyc = 2'b11; a_stb = 2'b11; a_sack = 1'b0;
    @(negedge clk);
    check("rst_idle_grant", a_grant, 2'b00);
    tick();
    @(negedge clk);
    check("rst_first_m0", a_grant, 2'b01);
    tick();

    // Fixed priority: master 0 re-requests after each 1-transfer tenure
    do_reset();
    prev_ack0 = 1'b0;
    n_ack0    = 0;
    for (int i = 0; i < 30; i++) begin
      b_cyc  = {1'b1, ~prev_ack0};
      b_stb  = b_cyc;
      b_sack = 1'b1;
      @(negedge clk);
      check("fp_no_m1_grant", b_grant[1], 1'b0);
      if (b_mack[0]) n_ack0++;
      prev_ack0 = b_mack[0];
      tick();
    end
    check("fp_m0_tenures", n_ack0, 10);

    // Four-master round-robin, all requesting, 1-transfer tenures
    do_reset();
    c_drop = '0;
    prev_g = '0;
    for (int i = 0; i < 20; i++) begin
      c_cyc  = ~c_drop;
      c_stb  = c_cyc;
      c_sack = 1'b1;
      @(negedge clk);
      if (c_grant != 4'b0 && prev_g == 4'b0) begin
        for (int k = 0; k < C_N; k++) if (c_grant[k]) order.push_back(k);
      end
      prev_g = c_grant;
      c_drop = c_mack;
      tick();
    end
    check("rr4_tenures", order.size(), 7);
    for (int i = 0; i < 5; i++) begin
      if (i < order.size()) check("rr4_order", order[i], i % C_N);
    end

    // Randomized traffic on instance C against the reference model
    do_reset();
    m_owner = -1; m_last = C_N - 1; m_cnt = 0; n_to = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < C_N; k++) begin
        if ($urandom_range(0, 7) == 0) c_cyc[k] = ~c_cyc[k];
        c_stb[k] = c_cyc[k] & ($urandom_range(0, 3) != 0);
        c_we[k]  = 1'($urandom_range(0, 1));
      end
      c_adr  = {$urandom, $urandom, $urandom, $urandom};
      c_dat  = {$urandom, $urandom, $urandom, $urandom};
      c_sel  = 16'($urandom);
      c_sack = ($urandom_range(0, 4) == 0);
      c_sdat = $urandom;

      owned   = (m_owner >= 0);
      o       = owned ? m_owner : 0;
      ocyc    = owned && c_cyc[o];
      ostb    = ocyc && c_stb[o];
      to      = ostb && !c_sack && (m_cnt == C_T - 1);
      e_grant = owned ? (4'b0001 << o) : 4'b0000;
      e_mack  = (owned && c_sack && c_stb[o]) ? e_grant : 4'b0000;
      e_merr  = to ? e_grant : 4'b0000;
      e_sadr  = owned ? c_adr[o*AW +: AW] : '0;
      e_ssel  = owned ? c_sel[o*SW +: SW] : '0;
      if (to) n_to++;

      @(negedge clk);
      check("rnd_grant", c_grant, e_grant);
      check("rnd_mack", c_mack, e_mack);
      check("rnd_merr", c_merr, e_merr);
      check("rnd_scyc", c_scyc, ocyc && !to);
      check("rnd_sstb", c_sstb, ostb && !to);
      check("rnd_sadr", c_sadr, e_sadr);
      check("rnd_ssel", c_ssel, e_ssel);
      check("rnd_busy", c_busy, owned);

      if (!owned) begin
        if (c_cyc != '0) begin
          for (int k = 1; k <= C_N; k++) begin
            if (m_owner < 0 && c_cyc[(m_last + k) % C_N]) m_owner = (m_last + k) % C_N;
          end
          m_last = m_owner;
        end
        m_cnt = 0;
      end else if (!ocyc) begin
        m_owner = -1;
        m_cnt   = 0;
      end else begin
        m_cnt = (ostb && !c_sack && !to) ? m_cnt + 1 : 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Parametrised Wishbone classic arbiter that merges NUM_MASTERS CPU-side master ports onto one shared slave bus. Example masters are the IF fetch port and the MEM data port. Supports round-robin or fixed-priority arbitration, bus locking for the whole owner tenure, and an optional per-transfer ack timeout that returns an error to the owner. Sits between cpu_master and the SRAM/UART bus in the SoC top.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 32, Wishbone data width; sel width is DATA_WIDTH/8
FIXED_PRIORITY, 0, 0 = round-robin, 1 = lowest index always wins
TIMEOUT_CYCLES, 0, ack timeout in cycles; 0 = disabled; otherwise 1..65535

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m_cyc_i  in  NUM_MASTERS  per-master cyc
m_stb_i  in  NUM_MASTERS  per-master stb
m_we_i  in  NUM_MASTERS  per-master we
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  packed byte selects
m_ack_o  out  NUM_MASTERS  ack routed to the owner only
m_err_o  out  NUM_MASTERS  timeout error routed to the owner only
m_dat_o  out  DATA_WIDTH  read data broadcast (s_dat_i passthrough)
s_cyc_o  out  1  slave cyc
s_stb_o  out  1  slave stb
s_we_o  out  1  slave we
s_adr_o  out  ADDR_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_sel_o  out  DATA_WIDTH/8  slave byte select
s_ack_i  in  1  slave ack
s_dat_i  in  DATA_WIDTH  slave read data
grant_o  out  NUM_MASTERS  registered one-hot owner, all-zero when idle
busy_o  out  1  high while in OWNED state

Behaviour:
- Reset (async, active-high) forces:
  - state = IDLE, grant_o = 0, busy_o = 0, timeout counter = 0.
  - Round-robin pointer last = NUM_MASTERS-1, so master 0 wins first.
  - All s_* outputs 0; m_ack_o = 0, m_err_o = 0.
  - Reset mid-transfer abandons the transfer silently; no ack or err is issued.
- FSM states: IDLE, OWNED.
- IDLE:
  - If any m_cyc_i is high, pick a winner and move to OWNED. grant_o is registered: the winner is granted at the next edge (1-cycle arbitration latency).
  - Winner selection, FIXED_PRIORITY=1: lowest asserted index.
  - Winner selection, FIXED_PRIORITY=0: first asserted index searching last+1, last+2, ... modulo NUM_MASTERS. `last` updates to the winner on grant.
- OWNED:
  - s_cyc/s_stb/s_we/s_adr/s_dat/s_sel = combinational mux of the owner's inputs.
  - m_ack_o[owner] = s_ack_i & m_stb_i[owner]; all other m_ack_o bits are 0.
  - Ownership is held, and other requests ignored, while m_cyc_i[owner] stays high. This permits back-to-back transfers.
  - When m_cyc_i[owner] is low, s_cyc_o/s_stb_o are 0 that cycle, and at the next edge state = IDLE and grant_o = 0. There is always at least one IDLE cycle between tenures.
- s_ack_i outside OWNED, or while owner stb is low, is ignored.
- Timeout (TIMEOUT_CYCLES = T > 0):
  - 16-bit counter increments each OWNED cycle with s_stb_o=1 and s_ack_i=0. It clears on ack, on stb low, and on leaving OWNED.
  - When counter == T-1 and no ack: m_err_o[owner] = 1 for exactly that one cycle, and s_cyc_o/s_stb_o are forced to 0 that cycle.
  - Counter clears. Ownership is retained; the master decides whether to retry or drop cyc.
  - Ack arriving on the same cycle as the timeout: the ack wins, no err.
- Simultaneous release and new request: the new request is seen only in the following IDLE cycle.
- NUM_MASTERS=1: the arbiter degenerates to a registered-grant passthrough. The same timing rules apply.

Decomposition:
- Package wb_arb_pkg:
  - typedef arb_state_t {IDLE, OWNED}.
  - Localparam IDX_W = $clog2(NUM_MASTERS), computed in the module because it depends on NUM_MASTERS.
  - Function rr_pick(req, last) returning the one-hot winner.
- Sub-module wb_arb_timeout: counter plus compare, outputs a timeout pulse. Instantiated only when TIMEOUT_CYCLES > 0 via generate.

Test Plan:
- Reset then m_cyc_i=2'b11, FIXED_PRIORITY=0 -> grant_o=2'b01 one cycle later. Master 0 drops cyc after 1 ack -> one IDLE cycle -> grant_o=2'b10.
- FIXED_PRIORITY=1, masters 0 and 1 both requesting continuously, each tenure 1 transfer -> grant always goes to master 0; master 1 never granted while master 0 re-requests.
- Owner master 1 with m_adr=32'h8000_0010, m_sel=4'b0011, we=1 -> s_adr_o=32'h8000_0010, s_sel_o=4'b0011. s_ack_i pulse -> m_ack_o=2'b10 exactly that cycle.
- TIMEOUT_CYCLES=4, slave never acks -> m_err_o[owner] high on the 4th stb cycle only, s_stb_o low that cycle. With ack on the 4th cycle -> ack only, no err.
- Assert reset mid-transfer (s_stb_o=1) -> all outputs 0 asynchronously, grant_o=0. After release, master 0 is granted first.
- NUM_MASTERS=4 round-robin with all requesting, 1-transfer tenures -> grant order 0,1,2,3,0 with one IDLE cycle between each.
